ahb_burst_master: RTL

- Synthesisable, parametrised AHB master engine; next generation of the bench-only single-beat write/read master.
- Accepts read/write commands of 1..MAX_LEN beats on a valid/ready port and drives pipelined AHB NONSEQ/SEQ transfers into the AHB2APB bridge.
- Handles slave wait states (Hreadyout low) and two-cycle ERROR responses.
- Returns read data and a completion status to the command source.

---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_addr_gen.sv | 43 ++++
 rtl/ahb_burst_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB transfer/response encodings and engine state type.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_addr_gen.sv
// ============================================================================
//  Module   : ahb_addr_gen
//  Purpose  : Next-beat address: increment, 1KB boundary detect, wrap masking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              wrap,
    output logic [ADDR_W-1:0] next_addr,
    output logic              force_nonseq
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BSHIFT = $clog2(BYTES);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        incr = addr + ADDR_W'(BYTES);
        mask = (ADDR_W'(len) << BSHIFT) - ADDR_W'(1);
        if (wrap) begin
            // Wrapping bursts stay inside one aligned block, so never split at 1KB
            next_addr    = (addr & ~mask) | (incr & mask);
            force_nonseq = 1'b0;
        end else begin
            next_addr    = incr;
            force_nonseq = (incr[9:0] == 10'd0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_burst_master.sv
// ============================================================================
//  Module   : ahb_burst_master
//  Purpose  : Pipelined AHB burst master (INCR, optional WRAP4/8/16 when
//             AHB_WRAP_BURST_EN is defined) with wait-state and ERROR handling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_wrap,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    input  logic              Hreadyout,
    input  logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Hrdata,
    output logic              Hwrite,
    output logic              Hreadyin,
    output logic [1:0]        Htrans,
    output logic [ADDR_W-1:0] Haddr,
    output logic [DATA_W-1:0] Hwdata
);

    localparam int BYTES = DATA_W / 8;

    state_t            state;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  burst_len;
    logic              wrap_burst;
    logic              dp_valid;
    logic              err_seen;
    logic [LEN_W-1:0]  len_eff;
    logic              start_wrap;
    logic              resp_err;
    logic [ADDR_W-1:0] next_addr;
    logic              force_nonseq;

    assign len_eff  = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
    assign resp_err = (Hresp != HRESP_OKAY);
    assign Hreadyin = Hreadyout;

    // High in the cycle whose closing edge accepts a write address and loads Hwdata
    assign wr_data_ready = (state == ST_ADDR) && Hwrite && Hreadyout;

`ifdef AHB_WRAP_BURST_EN
    assign start_wrap = cmd_wrap && ((len_eff == LEN_W'(4)) ||
                                     (len_eff == LEN_W'(8)) ||
                                     (len_eff == LEN_W'(16)));
`else
    logic unused_wrap;
    assign unused_wrap = cmd_wrap;
    assign start_wrap  = 1'b0;
`endif

    ahb_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .addr         (Haddr),
        .len          (burst_len),
        .wrap         (wrap_burst),
        .next_addr    (next_addr),
        .force_nonseq (force_nonseq)
    );

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            Htrans     <= HTRANS_IDLE;
            Haddr      <= '0;
            Hwrite     <= 1'b0;
            Hwdata     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            beats_left <= '0;
            burst_len  <= '0;
            wrap_burst <= 1'b0;
            dp_valid   <= 1'b0;
            err_seen   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        Htrans     <= HTRANS_NONSEQ;
                        Haddr      <= cmd_addr & ~ADDR_W'(BYTES - 1);
                        Hwrite     <= cmd_write;
                        beats_left <= len_eff;
                        burst_len  <= len_eff;
                        wrap_burst <= start_wrap;
                        err_seen   <= 1'b0;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_LAST: begin
                    if (dp_valid && !Hreadyout && resp_err) begin
                        // First ERROR cycle: withdraw any pending address phase
                        Htrans <= HTRANS_IDLE;
                        state  <= ST_ERR;
                    end else if (Hreadyout) begin
                        if (dp_valid && !Hwrite && !resp_err) begin
                            rd_valid <= 1'b1;
                            rd_data  <= Hrdata;
                        end
                        if (dp_valid && resp_err) begin
                            err_seen <= 1'b1;
                        end
                        if (state == ST_LAST) begin
                            dp_valid <= 1'b0;
                            done     <= 1'b1;
                            err      <= err_seen || resp_err;
                            state    <= ST_DONE;
                        end else begin
                            dp_valid <= 1'b1;
                            if (Hwrite) begin
                                Hwdata <= wr_data;
                            end
                            if (beats_left > LEN_W'(1)) begin
                                Haddr      <= next_addr;
                                Htrans     <= force_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                                beats_left <= beats_left - LEN_W'(1);
                            end else begin
                                Htrans <= HTRANS_IDLE;
                                state  <= ST_LAST;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    if (Hreadyout) begin
                        dp_valid <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
